// File: rtl/sd_dram_writer.sv
// SD loader DRAM writer: 32-bit word FIFO feeding a we/busy DRAM handshake at consecutive addresses.
// Optional running checksum output when SD_CHECKSUM_EN is defined.
module sd_dram_writer #(
  parameter int          FIFO_AW   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk27mhz,
  input  logic        reset,
  input  logic [31:0] i_data,
  input  logic        i_we,
  input  logic        i_done,
  input  logic        i_dram_busy,
  output logic        o_dram_we,
  output logic [31:0] o_dram_addr,
  output logic [31:0] o_dram_wdata,
  output logic        o_load_done,
  output logic        o_overflow,
`ifdef SD_CHECKSUM_EN
  output logic [31:0] o_checksum,
`endif
  output logic [31:0] o_words
);

  localparam int             DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                   state_q, state_d;
  logic [DEPTH-1:0][31:0]   mem_q, mem_d;
  logic [FIFO_AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [31:0]              addr_q, addr_d, wdata_q, wdata_d, words_q, words_d;
  logic                     load_done_q, load_done_d, overflow_q, overflow_d;
  logic                     full, empty, push, pop;
`ifdef SD_CHECKSUM_EN
  logic [31:0]              csum_q, csum_d;
`endif

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = i_we && !full && !load_done_q;
  assign pop   = (state_q == IDLE) && !empty && !i_dram_busy;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    words_d     = words_q;
`ifdef SD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (push) begin
      mem_d[wr_ptr_q[FIFO_AW-1:0]] = i_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case (state_q)
      IDLE: if (pop) begin
        wdata_d  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ISSUE;
      end
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (i_dram_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!i_dram_busy) begin
        addr_d  = addr_q + 32'd4;
        words_d = words_q + 32'd1;
`ifdef SD_CHECKSUM_EN
        csum_d  = csum_q + wdata_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_done_d = load_done_q | (i_done && empty && (state_q == IDLE));
    overflow_d  = overflow_q | (i_we && full && !load_done_q);
  end

  always_ff @(posedge clk27mhz) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      words_q     <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      words_q     <= words_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
`ifdef SD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign o_dram_we    = (state_q == ISSUE);
  assign o_dram_addr  = addr_q;
  assign o_dram_wdata = wdata_q;
  assign o_load_done  = load_done_q;
  assign o_overflow   = overflow_q;
  assign o_words      = words_q;
`ifdef SD_CHECKSUM_EN
  assign o_checksum   = csum_q;
`endif

endmodule
